// File: rtl/accum_writeback_ctrl.sv
// accum_writeback_ctrl
// Drains the 64-bit word-count counters held in accum_array and streams
// them to host memory through the AXI write master. Counters are read
// one per cycle, packed eight to a 512-bit beat, and sent in page-sized
// bursts. Each burst is announced with a one-cycle ctrl_start and closed
// by the master's ctrl_done.

module accum_writeback_ctrl #(
    parameter int WRITE_PAGESIZE = 4096,
    parameter int RD_LATENCY     = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         kick,
    output logic         busy,
    input  logic [31:0]  num_of_entries,
    input  logic [63:0]  memory_offset,
    output logic [31:0]  accum_raddr,
    output logic         accum_re,
    input  logic [63:0]  accum_rdout,
    output logic         ctrl_start,
    input  logic         ctrl_done,
    output logic [63:0]  ctrl_addr_offset,
    output logic [31:0]  ctrl_xfer_size_in_bytes,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    output logic [511:0] m_axis_tdata,
    output logic         m_axis_tlast
);

    // Number of 64-bit counters that fit in one burst.
    localparam logic [31:0] PAGE_ENTRIES = 32'(WRITE_PAGESIZE / 8);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PAGE      = 3'd1,
        ST_FETCH     = 3'd2,
        ST_SEND      = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_t;

    state_t state_r;

    // Job and page bookkeeping.
    logic [31:0] rest_r;        // entries not yet assigned to a page
    logic [63:0] addr_r;        // byte address of the next page
    logic [31:0] rd_ptr_r;      // next accum_array address to read
    logic [31:0] page_left_r;   // entries of the current page not yet read
    logic [31:0] page_beats_r;  // beats in the current page
    logic [31:0] beat_cnt_r;    // beats of the current page already sent
    logic        done_seen_r;   // ctrl_done arrived before WAIT_DONE
    logic [3:0]  lane_issue_r;  // reads issued into the beat being packed (0..8)
    logic [2:0]  accum_lane_r;  // pack lane of the read currently on accum_re

    // Read-return tracking: one stage per cycle of accum_array latency.
    logic [RD_LATENCY-1:0] re_pipe_r;
    logic [2:0]            lane_pipe_r [RD_LATENCY];

    // Derived per-page quantities and fetch/capture controls.
    logic [31:0] pe_s;
    logic [31:0] page_beats_s;
    logic        can_issue_s;
    logic        fetch_done_s;
    logic        capture_s;
    logic [2:0]  capture_lane_s;
    logic        last_beat_s;

    // Entries in the next page: whatever remains, capped at one page.
    always_comb begin
        if (rest_r < PAGE_ENTRIES) begin
            pe_s = rest_r;
        end else begin
            pe_s = PAGE_ENTRIES;
        end
    end

    // Beat count of the next page and the fetch/capture handshakes.
    always_comb begin
        // pe_s never exceeds one page, so the +7 cannot overflow.
        page_beats_s   = (pe_s + 32'd7) >> 3;
        can_issue_s    = (lane_issue_r < 4'd8) && (page_left_r != 32'd0);
        capture_s      = re_pipe_r[RD_LATENCY-1];
        capture_lane_s = lane_pipe_r[RD_LATENCY-1];
        // Done only when nothing is left to issue, nothing is on the bus
        // and nothing is still in flight through the read latency.
        fetch_done_s   = !can_issue_s && !accum_re &&
                         (re_pipe_r == {RD_LATENCY{1'b0}});
        last_beat_s    = (beat_cnt_r == (page_beats_r - 32'd1));
    end

    // Delay line that marks when each issued read's data is on accum_rdout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            re_pipe_r <= {RD_LATENCY{1'b0}};
            for (int i = 0; i < RD_LATENCY; i++) begin
                lane_pipe_r[i] <= 3'd0;
            end
        end else begin
            re_pipe_r[0]   <= accum_re;
            lane_pipe_r[0] <= accum_lane_r;
            for (int i = 1; i < RD_LATENCY; i++) begin
                re_pipe_r[i]   <= re_pipe_r[i-1];
                lane_pipe_r[i] <= lane_pipe_r[i-1];
            end
        end
    end

    // Main controller: job capture, page setup, fetch, send and completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r                 <= ST_IDLE;
            busy                    <= 1'b0;
            accum_raddr             <= 32'd0;
            accum_re                <= 1'b0;
            ctrl_start              <= 1'b0;
            ctrl_addr_offset        <= 64'd0;
            ctrl_xfer_size_in_bytes <= 32'd0;
            m_axis_tvalid           <= 1'b0;
            m_axis_tdata            <= 512'd0;
            m_axis_tlast            <= 1'b0;
            rest_r                  <= 32'd0;
            addr_r                  <= 64'd0;
            rd_ptr_r                <= 32'd0;
            page_left_r             <= 32'd0;
            page_beats_r            <= 32'd0;
            beat_cnt_r              <= 32'd0;
            done_seen_r             <= 1'b0;
            lane_issue_r            <= 4'd0;
            accum_lane_r            <= 3'd0;
        end else begin
            ctrl_start <= 1'b0;
            accum_re   <= 1'b0;

            // A completion can only belong to a burst that has started, so
            // the flag is cleared whenever a new burst is about to start.
            if ((state_r == ST_IDLE) || (state_r == ST_PAGE)) begin
                done_seen_r <= 1'b0;
            end else if (ctrl_done) begin
                done_seen_r <= 1'b1;
            end else begin
                done_seen_r <= done_seen_r;
            end

            // Returning read data lands in the lane it was issued for.
            if (capture_s) begin
                m_axis_tdata[{capture_lane_s, 6'd0} +: 64] <= accum_rdout;
            end

            case (state_r)
                ST_IDLE: begin
                    if (kick) begin
                        rest_r   <= num_of_entries;
                        addr_r   <= memory_offset;
                        rd_ptr_r <= 32'd0;
                        busy     <= 1'b1;
                        state_r  <= ST_PAGE;
                    end
                end

                ST_PAGE: begin
                    if (rest_r == 32'd0) begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        ctrl_start              <= 1'b1;
                        ctrl_addr_offset        <= addr_r;
                        ctrl_xfer_size_in_bytes <= {page_beats_s[25:0], 6'd0};
                        page_beats_r            <= page_beats_s;
                        page_left_r             <= pe_s;
                        beat_cnt_r              <= 32'd0;
                        lane_issue_r            <= 4'd0;
                        addr_r                  <= addr_r + 64'({page_beats_s, 6'd0});
                        rest_r                  <= rest_r - pe_s;
                        state_r                 <= ST_FETCH;
                    end
                end

                ST_FETCH: begin
                    if (can_issue_s) begin
                        accum_re     <= 1'b1;
                        accum_raddr  <= rd_ptr_r;
                        accum_lane_r <= lane_issue_r[2:0];
                        rd_ptr_r     <= rd_ptr_r + 32'd1;
                        lane_issue_r <= lane_issue_r + 4'd1;
                        page_left_r  <= page_left_r - 32'd1;
                    end else if (fetch_done_s) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= last_beat_s;
                        state_r       <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    // tdata/tvalid are left untouched until the beat is taken.
                    if (m_axis_tready) begin
                        m_axis_tvalid <= 1'b0;
                        m_axis_tlast  <= 1'b0;
                        m_axis_tdata  <= 512'd0;
                        beat_cnt_r    <= beat_cnt_r + 32'd1;
                        lane_issue_r  <= 4'd0;
                        if (m_axis_tlast) begin
                            state_r <= ST_WAIT_DONE;
                        end else begin
                            state_r <= ST_FETCH;
                        end
                    end
                end

                ST_WAIT_DONE: begin
                    if (done_seen_r || ctrl_done) begin
                        state_r <= ST_PAGE;
                    end
                end

                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accum_writeback_ctrl.sv
// Self-checking bench for accum_writeback_ctrl. Two instances run side by
// side (read latency 1 and 3) on the same job requests; each has its own
// accum_array model, write-master responder and compare process. The
// expected burst/beat stream is computed from the job parameters alone.

module tb_accum_writeback_ctrl;

    localparam int PAGE_ENT = 512;   // 4096-byte pages of 8-byte counters

    logic clk = 1'b0;
    logic reset;
    logic kick;
    logic [31:0] num;
    logic [63:0] off;

    logic         busy     [2];
    logic [31:0]  raddr    [2];
    logic         accum_re [2];
    logic [63:0]  rdout    [2];
    logic         cstart   [2];
    logic         cdone    [2];
    logic [63:0]  caddr    [2];
    logic [31:0]  csize    [2];
    logic         tvalid   [2];
    logic         tready   [2];
    logic [511:0] tdata    [2];
    logic         tlast    [2];

    int checks;
    int errors;
    int cyc = 0;
    int rmode;   // 0: tready always 1, 1: pattern 1,0,0,1,0,1, 2: 3-cycle stall per beat
    int dmode;   // 0: ctrl_done 4 cycles after last beat, 1: ctrl_done during last-beat stall

    // Expected stream
    logic [511:0] exp_data [256];
    logic         exp_last [256];
    logic [63:0]  exp_addr [8];
    logic [31:0]  exp_size [8];
    int exp_nbeats;
    int exp_nbursts;
    int exp_nreads;

    // Per-instance progress through the expected stream
    int beat_idx    [2];
    int burst_idx   [2];
    int rd_idx      [2];
    int busy_cycles [2];
    int done_cyc    [2];
    int fall_cyc    [2];
    logic awaiting  [2];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] mem_val(input logic [31:0] a);
        return {32'd0, a} + 64'd1;
    endfunction

    task automatic chk(input bit ok, input string name, input int g,
                       input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s inst%0d actual %0h required %0h", name, g, act, req);
        end
    endtask

    // Page/beat layout of a job, from entry count and start address alone.
    task automatic build_model(input logic [31:0] n, input logic [63:0] o);
        logic [31:0]  rest;
        logic [63:0]  a;
        logic [31:0]  ptr;
        int           pe;
        int           beats;
        logic [511:0] d;
        rest = n; a = o; ptr = 32'd0;
        exp_nbeats = 0; exp_nbursts = 0; exp_nreads = int'(n);
        while (rest != 32'd0) begin
            pe    = (rest < 32'(PAGE_ENT)) ? int'(rest) : PAGE_ENT;
            beats = (pe + 7) / 8;
            exp_addr[exp_nbursts] = a;
            exp_size[exp_nbursts] = 32'(beats * 64);
            exp_nbursts++;
            for (int b = 0; b < beats; b++) begin
                d = 512'd0;
                for (int k = 0; k < 8; k++) begin
                    if (b * 8 + k < pe) d[64*k +: 64] = mem_val(ptr + 32'(b * 8 + k));
                end
                exp_data[exp_nbeats] = d;
                exp_last[exp_nbeats] = (b == beats - 1);
                exp_nbeats++;
            end
            ptr  = ptr + 32'(pe);
            a    = a + 64'(beats * 64);
            rest = rest - 32'(pe);
        end
        for (int g = 0; g < 2; g++) begin
            beat_idx[g] = 0; burst_idx[g] = 0; rd_idx[g] = 0;
            busy_cycles[g] = 0; done_cyc[g] = 0; fall_cyc[g] = 0;
        end
    endtask

    task automatic check_zero(input string name);
        for (int g = 0; g < 2; g++) begin
            chk({busy[g], cstart[g], accum_re[g], tvalid[g], tlast[g], raddr[g], caddr[g], csize[g]} == 133'd0,
                name, g,
                512'({busy[g], cstart[g], accum_re[g], tvalid[g], tlast[g], raddr[g], caddr[g], csize[g]}),
                512'd0);
            chk(tdata[g] == 512'd0, {name, "_tdata"}, g, tdata[g], 512'd0);
        end
    endtask

    task automatic start_test(input logic [31:0] n, input logic [63:0] o, input int rm, input int dm);
        build_model(n, o);
        rmode = rm;
        dmode = dm;
        @(negedge clk);
        num  = n;
        off  = o;
        kick = 1'b1;
        @(negedge clk);
        kick = 1'b0;
    endtask

    task automatic finish_test(input string name);
        int n;
        n = 0;
        repeat (3) @(negedge clk);
        while ((busy[0] || busy[1]) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk(n < 20000, {name, "_idle_timeout"}, 0, 512'(n), 512'd20000);
        repeat (6) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk(beat_idx[g] == exp_nbeats, {name, "_beats"}, g, 512'(beat_idx[g]), 512'(exp_nbeats));
            chk(burst_idx[g] == exp_nbursts, {name, "_bursts"}, g, 512'(burst_idx[g]), 512'(exp_nbursts));
            chk(rd_idx[g] == exp_nreads, {name, "_reads"}, g, 512'(rd_idx[g]), 512'(exp_nreads));
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int LAT = (gi == 0) ? 1 : 3;
        localparam int G   = gi;

        accum_writeback_ctrl #(
            .WRITE_PAGESIZE(4096),
            .RD_LATENCY    (LAT)
        ) dut (
            .clk                    (clk),
            .reset                  (reset),
            .kick                   (kick),
            .busy                   (busy[G]),
            .num_of_entries         (num),
            .memory_offset          (off),
            .accum_raddr            (raddr[G]),
            .accum_re               (accum_re[G]),
            .accum_rdout            (rdout[G]),
            .ctrl_start             (cstart[G]),
            .ctrl_done              (cdone[G]),
            .ctrl_addr_offset       (caddr[G]),
            .ctrl_xfer_size_in_bytes(csize[G]),
            .m_axis_tvalid          (tvalid[G]),
            .m_axis_tready          (tready[G]),
            .m_axis_tdata           (tdata[G]),
            .m_axis_tlast           (tlast[G])
        );

        // accum_array model, write-master responder and compare process
        initial begin : resp
            logic         re_h [5];
            logic [31:0]  ad_h [5];
            logic [511:0] prev_data;
            logic         prev_stall;
            logic         prev_busy;
            logic         tr;
            logic         cd;
            logic [5:0]   pat;
            int           stall_cnt;
            int           done_cnt;
            int           pcnt;
            pat = 6'b101001;
            for (int i = 0; i < 5; i++) begin re_h[i] = 1'b0; ad_h[i] = 32'd0; end
            prev_data = 512'd0; prev_stall = 1'b0; prev_busy = 1'b0;
            stall_cnt = 0; done_cnt = 0; pcnt = 0;
            tready[G] = 1'b0; cdone[G] = 1'b0; rdout[G] = 64'd0; awaiting[G] = 1'b0;
            forever begin
                @(posedge clk);
                #1;
                if (!reset) begin
                    for (int i = 0; i < 5; i++) re_h[i] = 1'b0;
                    prev_stall = 1'b0; prev_busy = 1'b0;
                    stall_cnt = 0; done_cnt = 0;
                    tready[G] = 1'b0; cdone[G] = 1'b0; rdout[G] = 64'd0; awaiting[G] = 1'b0;
                end else begin
                    // read port: data appears LAT cycles after the request
                    for (int i = 4; i > 0; i--) begin re_h[i] = re_h[i-1]; ad_h[i] = ad_h[i-1]; end
                    re_h[0] = accum_re[G];
                    ad_h[0] = raddr[G];
                    rdout[G] = re_h[LAT] ? mem_val(ad_h[LAT]) : 64'hBAD0_BAD0_BAD0_BAD0;
                    if (accum_re[G]) begin
                        chk(rd_idx[G] < exp_nreads && raddr[G] == 32'(rd_idx[G]), "read_addr", G,
                            512'(raddr[G]), 512'(rd_idx[G]));
                        rd_idx[G]++;
                    end

                    if (busy[G]) busy_cycles[G]++;
                    if (prev_busy && !busy[G]) fall_cyc[G] = cyc;
                    prev_busy = busy[G];

                    if (cstart[G]) begin
                        chk(!awaiting[G], "start_before_done", G, 512'(awaiting[G]), 512'd0);
                        if (burst_idx[G] < exp_nbursts) begin
                            chk(caddr[G] == exp_addr[burst_idx[G]], "burst_addr", G,
                                512'(caddr[G]), 512'(exp_addr[burst_idx[G]]));
                            chk(csize[G] == exp_size[burst_idx[G]], "burst_size", G,
                                512'(csize[G]), 512'(exp_size[burst_idx[G]]));
                        end else begin
                            chk(1'b0, "extra_start", G, 512'(burst_idx[G]), 512'(exp_nbursts));
                        end
                        burst_idx[G]++;
                        awaiting[G] = 1'b1;
                    end

                    // held beat must not change while stalled
                    if (prev_stall) begin
                        chk(tvalid[G] && tdata[G] == prev_data, "stall_hold", G, tdata[G], prev_data);
                    end

                    case (rmode)
                        1:       begin tr = pat[pcnt % 6]; pcnt++; end
                        2:       tr = (stall_cnt >= 3);
                        default: tr = 1'b1;
                    endcase
                    tready[G] = tr;

                    cd = 1'b0;
                    if (done_cnt > 0) begin
                        done_cnt--;
                        if (done_cnt == 0) cd = 1'b1;
                    end
                    if (dmode == 1 && tvalid[G] && tlast[G] && stall_cnt == 0 && !tr) cd = 1'b1;
                    cdone[G] = cd;
                    if (cd) begin
                        awaiting[G] = 1'b0;
                        done_cyc[G] = cyc;
                    end

                    if (tvalid[G] && tr) begin
                        if (beat_idx[G] < exp_nbeats) begin
                            chk(tdata[G] == exp_data[beat_idx[G]], "beat_data", G, tdata[G], exp_data[beat_idx[G]]);
                            chk(tlast[G] == exp_last[beat_idx[G]], "beat_last", G, 512'(tlast[G]),
                                512'(exp_last[beat_idx[G]]));
                            if (exp_last[beat_idx[G]] && dmode == 0) done_cnt = 4;
                        end else begin
                            chk(1'b0, "extra_beat", G, 512'(beat_idx[G]), 512'(exp_nbeats));
                        end
                        beat_idx[G]++;
                        stall_cnt = 0;
                    end else if (tvalid[G]) begin
                        stall_cnt++;
                    end
                    prev_stall = tvalid[G] && !tr;
                    prev_data  = tdata[G];
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog inst0 actual timeout required finish");
        $fatal(1);
    end

    initial begin
        int n;
        checks = 0; errors = 0;
        reset = 1'b1; kick = 1'b0; num = 32'd0; off = 64'd0; rmode = 0; dmode = 0;
        exp_nbeats = 0; exp_nbursts = 0; exp_nreads = 0;
        for (int g = 0; g < 2; g++) begin
            beat_idx[g] = 0; burst_idx[g] = 0; rd_idx[g] = 0;
        end
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset_state");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // 8 entries: one burst, one full beat
        start_test(32'd8, 64'h1000, 0, 0);
        chk(exp_nbursts == 1 && exp_size[0] == 32'd64, "model_t1", 0, 512'(exp_size[0]), 512'd64);
        chk(exp_data[0][63:0] == 64'd1 && exp_data[0][511:448] == 64'd8, "model_t1_lanes", 0,
            exp_data[0], 512'd0);
        finish_test("t1");
        for (int g = 0; g < 2; g++)
            chk(fall_cyc[g] - done_cyc[g] == 2, "busy_fall", g, 512'(fall_cyc[g] - done_cyc[g]), 512'd2);

        // 10 entries: partial second beat
        start_test(32'd10, 64'h2000, 0, 0);
        chk(exp_data[1][127:64] == 64'd10 && exp_data[1][191:128] == 64'd0, "model_t2", 0,
            exp_data[1], 512'd0);
        finish_test("t2");

        // 1000 entries: two pages; a kick mid-job must be ignored
        start_test(32'd1000, 64'd0, 0, 0);
        chk(exp_nbeats == 125 && exp_addr[1] == 64'd4096 && exp_size[1] == 32'd3904, "model_t3", 0,
            512'(exp_size[1]), 512'd3904);
        chk(exp_last[63] && exp_last[124] && !exp_last[62], "model_t3_last", 0, 512'(exp_last[62]), 512'd0);
        repeat (100) @(negedge clk);
        num = 32'd5; kick = 1'b1;
        @(negedge clk);
        kick = 1'b0;
        finish_test("t3");

        // 64 entries with tready pattern 1,0,0,1,0,1
        start_test(32'd64, 64'h8000, 1, 0);
        finish_test("t4");

        // empty job
        start_test(32'd0, 64'h9000, 0, 0);
        finish_test("t5");
        for (int g = 0; g < 2; g++)
            chk(busy_cycles[g] == 1, "empty_busy", g, 512'(busy_cycles[g]), 512'd1);

        // early ctrl_done during last-beat stall, address wrap across 2^64
        start_test(32'd600, 64'hFFFF_FFFF_FFFF_F000, 2, 1);
        chk(exp_addr[1] == 64'd0 && exp_size[1] == 32'd704, "model_t6", 0, 512'(exp_addr[1]), 512'd0);
        finish_test("t6");

        // asynchronous reset in the middle of a fetch
        start_test(32'd64, 64'h5000, 0, 0);
        n = 0;
        while (rd_idx[0] < 3 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk(rd_idx[0] >= 3, "fetch_reached", 0, 512'(rd_idx[0]), 512'd3);
        #3 reset = 1'b0;
        #1 check_zero("reset_midfetch");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        start_test(32'd8, 64'h6000, 0, 0);
        finish_test("t7");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/accum_writeback_ctrl.md
Name: accum_writeback_ctrl

Overview:
- Drains word-count results from accum_array and writes them to host memory through the AXI write master (axonerve_kvs_rtl_example_axi_write_master).
- Write-side counterpart of the search/add read path.
- On kick, reads num_of_entries 64-bit counters starting at accum address 0 and packs 8 counters per 512-bit beat.
- Streams the beats in page-sized bursts starting at memory_offset.

Parameters:
- WRITE_PAGESIZE, 4096, maximum bytes per ctrl_start burst; must be a multiple of 64.
- RD_LATENCY, 1, accum_array read latency in cycles, from accum_raddr to accum_rdout; 1..4.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- kick  in  1  start request; sampled only in IDLE
- busy  out  1  high from the cycle after an accepted kick until the return to IDLE
- num_of_entries  in  32  counters to write; captured on kick
- memory_offset  in  64  destination byte address; captured on kick
- accum_raddr  out  32  accum_array read address
- accum_re  out  1  read enable
- accum_rdout  in  64  read data, valid RD_LATENCY cycles after accum_re
- ctrl_start  out  1  one-cycle pulse per page burst
- ctrl_done  in  1  burst-complete pulse from the write master
- ctrl_addr_offset  out  64  burst address; stable from ctrl_start until the next ctrl_start
- ctrl_xfer_size_in_bytes  out  32  burst size; stable from ctrl_start until the next ctrl_start
- m_axis_tvalid  out  1  beat valid
- m_axis_tready  in  1  write master accepts the beat
- m_axis_tdata  out  512  packed beat; counter k of the beat sits at bits [64k+63:64k]
- m_axis_tlast  out  1  last beat of the current burst

Behaviour:
- Reset (reset=0): state=IDLE; busy, ctrl_start, accum_re, m_axis_tvalid and m_axis_tlast are 0; accum_raddr, ctrl_addr_offset, ctrl_xfer_size_in_bytes and m_axis_tdata are 0. Reset applies immediately, including mid-burst; no pending ctrl_done is awaited.
- Internal registers:
  - rest = entries remaining (32 bit).
  - addr = next memory address (64 bit).
  - rd_ptr = next accum address.
  - page_beats, beat_cnt.
  - done_seen, a sticky flag.
- IDLE:
  - kick=1 captures rest=num_of_entries, addr=memory_offset, rd_ptr=0, sets busy=1 and goes to PAGE.
  - kick while busy is ignored.
- PAGE:
  - If rest=0, go to IDLE with busy=0. num_of_entries=0 therefore gives busy high for exactly 1 cycle, with no ctrl_start and no beats.
  - Otherwise: pe = min(rest, WRITE_PAGESIZE/8); page_beats = ceil(pe/8); ctrl_xfer_size_in_bytes = page_beats*64; ctrl_addr_offset = addr.
  - Pulse ctrl_start for 1 cycle, clear done_seen, beat_cnt=0, then go to FETCH.
  - Update addr += page_beats*64 and rest -= pe.
- FETCH:
  - Issue up to 8 reads, one per cycle, with accum_re=1 and accum_raddr=rd_ptr++.
  - Issue only while the issued count < pe for this page; lanes with no read are zero.
  - Capture accum_rdout into lane j exactly RD_LATENCY cycles after read j. This uses an accum_re shift register and a lane index pipeline.
  - When all issued reads have returned, go to SEND.
- SEND:
  - m_axis_tvalid=1, holding m_axis_tdata stable.
  - m_axis_tlast = (beat_cnt == page_beats-1).
  - On tvalid&tready: beat_cnt++, clear the pack register, tvalid=0.
  - If that was the last beat of the page, go to WAIT_DONE; otherwise go to FETCH.
  - tdata and tvalid must not change while tvalid=1 and tready=0.
- WAIT_DONE: when done_seen or ctrl_done, go to PAGE.
- ctrl_done may arrive in any busy state before WAIT_DONE; done_seen latches it and the pulse is not lost.
- Arithmetic:
  - Byte sizes are derived from entry counts per page, so there is no 32-bit overflow for any num_of_entries.
  - addr wraps modulo 2^64.
  - rd_ptr wraps modulo 2^32.
- Partial final beat: upper lanes are zero-filled; ctrl_xfer_size_in_bytes is always a multiple of 64.

Test Plan:
- num_of_entries=8, memory_offset=0x1000, accum[i]=i+1 -> one ctrl_start with addr 0x1000 and size 64; one beat with lanes 0..7 = 1..8 and tlast=1; busy falls 1 cycle after ctrl_done returns to IDLE.
- num_of_entries=10 -> size 128, 2 beats; beat 1 lanes 0,1 = 9,10 and lanes 2..7 = 0; tlast only on beat 1.
- num_of_entries=1000, offset 0 -> burst 1 is addr 0, size 4096, 64 beats; burst 2 is addr 4096, size 3904, 61 beats; tlast on beat 63 and beat 60; second ctrl_start only after the first ctrl_done.
- m_axis_tready pattern 1,0,0,1,0,1… with num_of_entries=64 -> exactly 8 beats, no duplicates or losses, tdata stable during stalls; repeat with RD_LATENCY=3.
- num_of_entries=0 -> no ctrl_start, no accum_re, busy=1 for exactly one cycle; kick pulsed while busy in any other test -> ignored.
- ctrl_done asserted early (during SEND of the last beat) -> no hang, next page proceeds. Reset asserted mid-FETCH -> all outputs 0 asynchronously; after release, a kick with num_of_entries=8 completes correctly.
